// File: rtl/mult_pipe_pkg.sv
// Shared types and helpers for the three-stage sliced multiplier.
// Op encoding, pipeline depth and per-op operand signedness live here.
package mult_pipe_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULXSS = 2'd1,
    MULXSU = 2'd2,
    MULXUU = 2'd3
  } mult_op_e;

  localparam int MULT_PIPE_LATENCY = 3;

  typedef struct packed {
    logic a_signed;
    logic b_signed;
  } op_sign_t;

  // Occupancy of each stage, exported for checkers.
  typedef struct packed {
    logic s1_valid;
    logic s2_valid;
    logic s3_valid;
  } pipe_dbg_t;

  // MUL returns the low word, which is identical for any signedness.
  function automatic op_sign_t op_signedness(input mult_op_e op);
    op_sign_t s;
    s = '0;
    case (op)
      MULXSS:  begin s.a_signed = 1'b1; s.b_signed = 1'b1; end
      MULXSU:  begin s.a_signed = 1'b1; s.b_signed = 1'b0; end
      default: begin s.a_signed = 1'b0; s.b_signed = 1'b0; end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mult_pipe_slice.sv
// One registered unsigned W x W hard-multiplier slice with enable and
// asynchronous clear; the product is held while en is low.
module mult_pipe_slice #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p <= '0;
    end else if (en) begin
      p <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end
  end

endmodule

// File: rtl/mult_pipe_unit.sv
// Three-stage pipelined multiplier: operand register, sliced partial
// products, then weighted sum with signed correction and word select.
module mult_pipe_unit
  import mult_pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16,
  parameter int TAG_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output pipe_dbg_t         dbg_stage_valid
);

  localparam int N  = DATA_W / SLICE_W;
  localparam int NP = N * N;
  localparam int PW = 2 * DATA_W;

  // Handshake: a transfer happens on a clock edge where valid && ready.
  // The whole pipe moves in lockstep on en; when the output word is held
  // by the consumer every stage freezes, so in_ready equals en.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------- S1: operands, op, tag ----------------
  logic              s1_valid;
  mult_op_e          s1_op;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [TAG_W-1:0]  s1_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op    <= MUL;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (en) begin
        s1_valid <= in_valid;
      end
      if (en) begin
        s1_op  <= mult_op_e'(in_op);
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_tag <= in_tag;
      end
    end
  end

  // ---------------- S2: partial products ----------------
  logic [2*SLICE_W-1:0] pp [NP];

  for (genvar i = 0; i < N; i++) begin : g_a
    for (genvar j = 0; j < N; j++) begin : g_b
      mult_pipe_slice #(
        .W (SLICE_W)
      ) u_slice (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .a     (s1_a[i*SLICE_W +: SLICE_W]),
        .b     (s1_b[j*SLICE_W +: SLICE_W]),
        .p     (pp[i*N+j])
      );
    end
  end

  // Full operands ride along for the signed correction in S3.
  logic              s2_valid;
  mult_op_e          s2_op;
  logic [DATA_W-1:0] s2_a;
  logic [DATA_W-1:0] s2_b;
  logic [TAG_W-1:0]  s2_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_op    <= MUL;
      s2_a     <= '0;
      s2_b     <= '0;
      s2_tag   <= '0;
    end else begin
      if (flush) begin
        s2_valid <= 1'b0;
      end else if (en) begin
        s2_valid <= s1_valid;
      end
      if (en) begin
        s2_op  <= s1_op;
        s2_a   <= s1_a;
        s2_b   <= s1_b;
        s2_tag <= s1_tag;
      end
    end
  end

  // ---------------- S3: sum, correct, select ----------------
  op_sign_t          s2_sign;
  logic [PW-1:0]     term;
  logic [PW-1:0]     prod;
  logic [DATA_W-1:0] s3_result;

  assign s2_sign = op_signedness(s2_op);

  // Unsigned product first; a negative signed operand then contributes
  // -2^DATA_W times the other operand, which the subtractions remove.
  always_comb begin
    term = '0;
    prod = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        term                = '0;
        term[2*SLICE_W-1:0] = pp[i*N+j];
        prod                = prod + (term << (SLICE_W * (i + j)));
      end
    end
    if (s2_sign.a_signed && s2_a[DATA_W-1]) begin
      prod = prod - {s2_b, {DATA_W{1'b0}}};
    end
    if (s2_sign.b_signed && s2_b[DATA_W-1]) begin
      prod = prod - {s2_a, {DATA_W{1'b0}}};
    end
  end

  assign s3_result = (s2_op == MUL) ? prod[DATA_W-1:0] : prod[PW-1:DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (en) begin
        out_valid <= s2_valid;
      end
      if (en) begin
        out_result <= s3_result;
        out_tag    <= s2_tag;
      end
    end
  end

  assign dbg_stage_valid = '{s1_valid: s1_valid, s2_valid: s2_valid, s3_valid: out_valid};

endmodule
